// File: rtl/boot_pkg.sv
// Shared types and constants for the UART boot loader controller.
package boot_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RECV,
      ST_ISSUE
   } state_e;

   localparam logic [7:0] CMD_WRITE = 8'h57;  // "W"
   localparam logic [7:0] CMD_GO    = 8'h47;  // "G"
   localparam logic [7:0] CMD_HALT  = 8'h48;  // "H"

   localparam int FRAME_BYTES = 8;
   localparam int CNT_W       = $clog2(FRAME_BYTES);

   // A loader write is only legal for word-aligned addresses below the limit.
   function automatic logic addr_ok(input logic [31:0] addr, input logic [31:0] limit);
      return (addr < limit) && (addr[1:0] == 2'b00);
   endfunction

endpackage

// File: rtl/frame_assembler.sv
// Collects the 8 frame bytes (addr LE, then data LE) and watches for inter-byte timeout.
module frame_assembler
   import boot_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 1_000_000
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic        active_in,
   input  logic        byte_valid_in,
   input  logic [7:0]  byte_in,
   output logic [31:0] addr_out,
   output logic [31:0] data_out,
   output logic        done_out,
   output logic        timeout_out
);

   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   logic [63:0]      buf_q, buf_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [TW-1:0]    idle_q, idle_d;

   // Shift bytes in from the top so byte 0 ends up in the low lane after 8 bytes.
   // done/timeout are combinational so the FSM leaves RECV on the sampling edge.
   always_comb begin
      buf_d       = buf_q;
      cnt_d       = cnt_q;
      idle_d      = idle_q;
      done_out    = 1'b0;
      timeout_out = 1'b0;
      if (!active_in) begin
         cnt_d  = '0;
         idle_d = '0;
      end else if (byte_valid_in) begin
         buf_d  = {byte_in, buf_q[63:8]};
         idle_d = '0;
         if (cnt_q == CNT_W'(FRAME_BYTES - 1)) begin
            done_out = 1'b1;
            cnt_d    = '0;
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end else if (idle_q == TW'(TIMEOUT_CYCLES - 1)) begin
         timeout_out = 1'b1;
         cnt_d       = '0;
         idle_d      = '0;
      end else if (idle_q < TW'(TIMEOUT_CYCLES)) begin
         idle_d = idle_q + TW'(1);
      end
   end

   // Buffer, byte counter and idle counter registers.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         buf_q  <= '0;
         cnt_q  <= '0;
         idle_q <= '0;
      end else begin
         buf_q  <= buf_d;
         cnt_q  <= cnt_d;
         idle_q <= idle_d;
      end
   end

   assign addr_out = buf_q[31:0];
   assign data_out = buf_q[63:32];

endmodule

// File: rtl/boot_loader_ctrl.sv
// UART boot loader: command decode, frame write issue, CPU run control and
// memory port arbitration with loader priority.
module boot_loader_ctrl
   import boot_pkg::*;
#(
   parameter logic [31:0] ADDR_LIMIT     = 32'h20000,
   parameter int          TIMEOUT_CYCLES = 1_000_000
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic [7:0]  rx_data_in,
   input  logic        rx_valid_in,
   input  logic        cpu_req_in,
   input  logic [31:0] cpu_addr_in,
   input  logic [31:0] cpu_data_in,
   input  logic [3:0]  cpu_we_in,
   output logic        cpu_stall_out,
   output logic        cpu_rst_out,
   output logic [31:0] mem_addr_out,
   output logic [31:0] mem_data_out,
   output logic [3:0]  mem_we_out,
   output logic        imem_we_out,
   output logic        frame_err_out,
   output logic [15:0] words_loaded_out
);

   state_e      state_q, state_d;
   logic        cpu_rst_q, cpu_rst_d;
   logic        frame_err_q, frame_err_d;
   logic [15:0] words_q, words_d;

   logic [31:0] asm_addr, asm_data;
   logic        asm_done, asm_timeout, frame_ok;

   frame_assembler #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_asm (
      .clk_in        (clk_in),
      .rst_in        (rst_in),
      .active_in     (state_q == ST_RECV),
      .byte_valid_in (rx_valid_in),
      .byte_in       (rx_data_in),
      .addr_out      (asm_addr),
      .data_out      (asm_data),
      .done_out      (asm_done),
      .timeout_out   (asm_timeout)
   );

   assign frame_ok = addr_ok(asm_addr, ADDR_LIMIT);

   // Next-state logic; ISSUE also decodes commands so a back-to-back "W" is not lost.
   always_comb begin
      state_d     = state_q;
      cpu_rst_d   = cpu_rst_q;
      frame_err_d = 1'b0;
      words_d     = words_q;
      case (state_q)
         ST_IDLE, ST_ISSUE: begin
            if (state_q == ST_ISSUE) begin
               state_d = ST_IDLE;
               if (frame_ok) begin
                  words_d = words_q + 16'd1;
               end else begin
                  frame_err_d = 1'b1;
               end
            end
            if (rx_valid_in) begin
               case (rx_data_in)
                  CMD_WRITE: state_d   = ST_RECV;
                  CMD_GO:    cpu_rst_d = 1'b0;
                  CMD_HALT:  cpu_rst_d = 1'b1;
                  default:   ;
               endcase
            end
         end
         ST_RECV: begin
            if (asm_done) begin
               state_d = ST_ISSUE;
            end else if (asm_timeout) begin
               state_d     = ST_IDLE;
               frame_err_d = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // FSM state and registered outputs; reset halts the CPU.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state_q     <= ST_IDLE;
         cpu_rst_q   <= 1'b1;
         frame_err_q <= 1'b0;
         words_q     <= '0;
      end else begin
         state_q     <= state_d;
         cpu_rst_q   <= cpu_rst_d;
         frame_err_q <= frame_err_d;
         words_q     <= words_d;
      end
   end

   // Memory port mux: loader owns the port in ISSUE, otherwise the CPU passes through.
   always_comb begin
      cpu_stall_out = 1'b0;
      imem_we_out   = 1'b0;
      mem_addr_out  = cpu_addr_in;
      mem_data_out  = cpu_data_in;
      mem_we_out    = (cpu_req_in && (cpu_addr_in < ADDR_LIMIT)) ? cpu_we_in : 4'b0000;
      if (state_q == ST_ISSUE) begin
         cpu_stall_out = cpu_req_in;
         mem_addr_out  = asm_addr;
         mem_data_out  = asm_data;
         mem_we_out    = frame_ok ? 4'b1111 : 4'b0000;
         imem_we_out   = frame_ok;
      end
   end

   assign cpu_rst_out      = cpu_rst_q;
   assign frame_err_out    = frame_err_q;
   assign words_loaded_out = words_q;

endmodule

// File: tb/tb_boot_loader_ctrl.sv
// Self-checking bench for boot_loader_ctrl: scoreboard of expected loader writes
// plus per-scenario inline checks.
module tb_boot_loader_ctrl;

   localparam logic [31:0] LIMIT = 32'h20000;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [7:0]  rx_data = 8'h00;
   logic        rx_valid = 1'b0;
   logic        cpu_req = 1'b0;
   logic [31:0] cpu_addr = '0;
   logic [31:0] cpu_data = '0;
   logic [3:0]  cpu_we = '0;
   logic        cpu_stall_out, cpu_rst_out, imem_we_out, frame_err_out;
   logic [31:0] mem_addr_out, mem_data_out;
   logic [3:0]  mem_we_out;
   logic [15:0] words_loaded_out;

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] data;
   } wr_t;

   wr_t         exp_q[$];
   int          n_checks = 0;
   int          n_errors = 0;
   int          err_seen = 0;
   int          stall_cnt = 0;
   logic        prev_stall = 1'b0;
   logic [3:0]  post_we = '0;
   logic [31:0] post_addr = '0;
   logic [15:0] exp_words = '0;

   always #5 clk = ~clk;

   boot_loader_ctrl #(
      .ADDR_LIMIT     (LIMIT),
      .TIMEOUT_CYCLES (50)
   ) dut (
      .clk_in           (clk),
      .rst_in           (rst),
      .rx_data_in       (rx_data),
      .rx_valid_in      (rx_valid),
      .cpu_req_in       (cpu_req),
      .cpu_addr_in      (cpu_addr),
      .cpu_data_in      (cpu_data),
      .cpu_we_in        (cpu_we),
      .cpu_stall_out    (cpu_stall_out),
      .cpu_rst_out      (cpu_rst_out),
      .mem_addr_out     (mem_addr_out),
      .mem_data_out     (mem_data_out),
      .mem_we_out       (mem_we_out),
      .imem_we_out      (imem_we_out),
      .frame_err_out    (frame_err_out),
      .words_loaded_out (words_loaded_out)
   );

   // Monitor: pops the scoreboard on every loader write, tracks error pulses and stalls.
   initial begin
      wr_t e;
      forever begin
         @(negedge clk);
         if (frame_err_out) err_seen++;
         if (prev_stall) begin
            post_we   = mem_we_out;
            post_addr = mem_addr_out;
         end
         prev_stall = cpu_stall_out;
         if (cpu_stall_out) stall_cnt++;
         if (imem_we_out) begin
            n_checks++;
            if (exp_q.size() == 0) begin
               n_errors++;
               $display("FAIL unexpected_write: addr=%h data=%h, no write expected", mem_addr_out, mem_data_out);
            end else begin
               e = exp_q.pop_front();
               if (mem_addr_out !== e.addr || mem_data_out !== e.data || mem_we_out !== 4'hF) begin
                  n_errors++;
                  $display("FAIL loader_write: got addr=%h data=%h we=%b, want addr=%h data=%h we=1111",
                           mem_addr_out, mem_data_out, mem_we_out, e.addr, e.data);
               end else begin
                  $display("write ok: addr=%h data=%h", mem_addr_out, mem_data_out);
               end
            end
         end else if (mem_we_out !== 4'b0000 && !cpu_req) begin
            n_errors++;
            $display("FAIL spurious_we: got mem_we=%b with no writer, want 0000", mem_we_out);
         end
      end
   end

   // Drive one byte for exactly one cycle; caller is positioned just after a rising edge.
   task automatic send_byte(input logic [7:0] b);
      rx_data  = b;
      rx_valid = 1'b1;
      @(posedge clk);
      #1 rx_valid = 1'b0;
   endtask

   task automatic send_body(input logic [31:0] addr, input logic [31:0] data);
      send_byte(8'h57);
      for (int i = 0; i < 4; i++) send_byte(addr[8*i +: 8]);
      for (int i = 0; i < 4; i++) send_byte(data[8*i +: 8]);
   endtask

   task automatic send_frame(input logic [31:0] addr, input logic [31:0] data);
      logic ok;
      int   err_base;
      ok = (addr < LIMIT) && (addr[1:0] == 2'b00);
      if (ok) begin
         exp_q.push_back('{addr: addr, data: data});
         exp_words = exp_words + 16'd1;
      end
      err_base = err_seen;
      send_body(addr, data);
      @(negedge clk);
      n_checks++;
      if (imem_we_out !== ok) begin
         n_errors++;
         $display("FAIL issue_latency: imem_we=%b in cycle after last byte, want %b", imem_we_out, ok);
      end
      @(posedge clk);
      @(negedge clk);
      n_checks++;
      if (err_seen != err_base + (ok ? 0 : 1)) begin
         n_errors++;
         $display("FAIL frame_err: pulses=%0d, want %0d", err_seen - err_base, ok ? 0 : 1);
      end
      n_checks++;
      if (words_loaded_out !== exp_words) begin
         n_errors++;
         $display("FAIL words_loaded: got %0d, want %0d", words_loaded_out, exp_words);
      end
      $display("frame addr=%h data=%h ok=%b words=%0d", addr, data, ok, words_loaded_out);
      @(posedge clk);
      #1;
   endtask

   task automatic check_reset_values(input string tag);
      n_checks++;
      if (cpu_rst_out !== 1'b1 || cpu_stall_out !== 1'b0 || mem_we_out !== 4'b0 ||
          imem_we_out !== 1'b0 || frame_err_out !== 1'b0 || words_loaded_out !== 16'd0) begin
         n_errors++;
         $display("FAIL %s: rst=%b stall=%b we=%b imem=%b err=%b words=%0d, want 1 0 0000 0 0 0",
                  tag, cpu_rst_out, cpu_stall_out, mem_we_out, imem_we_out, frame_err_out, words_loaded_out);
      end else begin
         $display("%s: outputs at reset values", tag);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1 check_reset_values("reset_state");
      rst = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic test_write_frame();
      send_frame(32'h0000_0100, 32'hDEAD_BEEF);
      send_frame(32'h0001_FFFC, 32'h0123_4567);
   endtask

   task automatic test_dropped();
      send_frame(32'h0002_0000, 32'h1111_1111);
      send_frame(32'h0000_0102, 32'h2222_2222);
   endtask

   task automatic test_cpu_path();
      cpu_req  = 1'b1;
      cpu_addr = 32'h0000_0080;
      cpu_data = 32'h0000_A5A5;
      cpu_we   = 4'b0101;
      @(negedge clk);
      n_checks++;
      if (mem_addr_out !== 32'h80 || mem_data_out !== 32'hA5A5 || mem_we_out !== 4'b0101 ||
          imem_we_out !== 1'b0 || cpu_stall_out !== 1'b0) begin
         n_errors++;
         $display("FAIL cpu_pass: addr=%h data=%h we=%b imem=%b stall=%b, want 80 a5a5 0101 0 0",
                  mem_addr_out, mem_data_out, mem_we_out, imem_we_out, cpu_stall_out);
      end
      cpu_addr = LIMIT;
      cpu_we   = 4'b1111;
      @(negedge clk);
      n_checks++;
      if (mem_we_out !== 4'b0000) begin
         n_errors++;
         $display("FAIL cpu_limit: mem_we=%b at addr %h, want 0000", mem_we_out, cpu_addr);
      end
      cpu_addr = LIMIT - 32'd4;
      @(negedge clk);
      n_checks++;
      if (mem_we_out !== 4'b1111) begin
         n_errors++;
         $display("FAIL cpu_below_limit: mem_we=%b at addr %h, want 1111", mem_we_out, cpu_addr);
      end
      $display("cpu path checked");
      cpu_req = 1'b0;
      cpu_we  = 4'b0000;
      @(posedge clk);
      #1;
   endtask

   task automatic test_contention();
      cpu_req   = 1'b1;
      cpu_addr  = 32'h0000_0040;
      cpu_data  = 32'hCAFE_F00D;
      cpu_we    = 4'b0011;
      stall_cnt = 0;
      send_frame(32'h0000_0200, 32'h0BAD_C0DE);
      n_checks++;
      if (stall_cnt != 1) begin
         n_errors++;
         $display("FAIL stall_count: got %0d stall cycles, want 1", stall_cnt);
      end
      n_checks++;
      if (post_we !== 4'b0011 || post_addr !== 32'h40) begin
         n_errors++;
         $display("FAIL cpu_after_stall: we=%b addr=%h, want 0011 40", post_we, post_addr);
      end
      $display("contention: stalls=%0d post_we=%b post_addr=%h", stall_cnt, post_we, post_addr);
      cpu_req = 1'b0;
      cpu_we  = 4'b0000;
   endtask

   task automatic test_timeout();
      int err_base;
      err_base = err_seen;
      send_byte(8'h57);
      send_byte(8'h10);
      send_byte(8'h20);
      send_byte(8'h30);
      repeat (45) @(posedge clk);
      #1;
      n_checks++;
      if (err_seen != err_base) begin
         n_errors++;
         $display("FAIL timeout_early: %0d pulses after 45 idle cycles, want 0", err_seen - err_base);
      end
      repeat (8) @(posedge clk);
      #1;
      n_checks++;
      if (err_seen != err_base + 1) begin
         n_errors++;
         $display("FAIL timeout_pulse: %0d pulses after 53 idle cycles, want 1", err_seen - err_base);
      end
      $display("timeout: pulses=%0d", err_seen - err_base);
      send_frame(32'h0000_0300, 32'h5566_7788);
   endtask

   task automatic test_run_control();
      send_byte(8'h47);
      @(negedge clk);
      n_checks++;
      if (cpu_rst_out !== 1'b0) begin
         n_errors++;
         $display("FAIL run_go: cpu_rst=%b, want 0", cpu_rst_out);
      end
      @(posedge clk);
      #1 send_byte(8'h48);
      @(negedge clk);
      n_checks++;
      if (cpu_rst_out !== 1'b1) begin
         n_errors++;
         $display("FAIL run_halt: cpu_rst=%b, want 1", cpu_rst_out);
      end
      @(posedge clk);
      #1 send_frame(32'h0000_0400, 32'h1122_4733);
      n_checks++;
      if (cpu_rst_out !== 1'b1) begin
         n_errors++;
         $display("FAIL go_in_frame: cpu_rst=%b, want 1", cpu_rst_out);
      end
      $display("run control: cpu_rst=%b", cpu_rst_out);
   endtask

   task automatic test_back_to_back();
      exp_q.push_back('{addr: 32'h0000_0500, data: 32'hA1A2_A3A4});
      exp_q.push_back('{addr: 32'h0000_0504, data: 32'hB1B2_B3B4});
      exp_words = exp_words + 16'd2;
      send_body(32'h0000_0500, 32'hA1A2_A3A4);
      send_body(32'h0000_0504, 32'hB1B2_B3B4);
      repeat (4) @(posedge clk);
      #1;
      n_checks++;
      if (exp_q.size() != 0) begin
         n_errors++;
         $display("FAIL back_to_back: %0d writes missing, want 0", exp_q.size());
      end
      n_checks++;
      if (words_loaded_out !== exp_words) begin
         n_errors++;
         $display("FAIL back_to_back_words: got %0d, want %0d", words_loaded_out, exp_words);
      end
      $display("back-to-back: words=%0d", words_loaded_out);
   endtask

   task automatic test_reset_mid_recv();
      send_byte(8'h47);
      send_byte(8'h57);
      for (int i = 0; i < 4; i++) send_byte(8'h00);
      rst = 1'b1;
      exp_words = 16'd0;
      #2 check_reset_values("reset_mid_recv");
      @(posedge clk);
      #1 rst = 1'b0;
      @(posedge clk);
      #1 send_frame(32'h0000_0600, 32'hFEED_FACE);
      n_checks++;
      if (exp_q.size() != 0) begin
         n_errors++;
         $display("FAIL pending_writes: %0d left, want 0", exp_q.size());
      end
   endtask

   initial begin
      test_reset();
      test_write_frame();
      test_dropped();
      test_cpu_path();
      test_contention();
      test_timeout();
      test_run_control();
      test_back_to_back();
      test_reset_mid_recv();
      repeat (3) @(posedge clk);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
